// File: rtl/cpu_pkg.sv
// Shared defaults and helpers for the program-counter sequencer slice.
package cpu_pkg;

  localparam int unsigned PC_W_DEF       = 10;
  localparam int unsigned DEPTH_DEF      = 8;
  localparam int unsigned N_IRQ_DEF      = 8;
  localparam int unsigned VEC_BASE_DEF   = 'h3C0;
  localparam int unsigned VEC_STRIDE_DEF = 4;

  // Winning event of a cycle, in decreasing priority: reti, pop, push, entry, nxt.
  typedef enum logic [2:0] {
    ACT_NXT,
    ACT_ENTRY,
    ACT_PUSH,
    ACT_POP,
    ACT_RETI
  } act_e;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned sp_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lifo_stack.sv
// Return-address LIFO: unreset storage, reset occupancy counter, top-of-stack read.
module lifo_stack
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = PC_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            din,
  output logic [WIDTH-1:0]            dout,
  output logic                        full,
  output logic                        empty,
  output logic [sp_width(DEPTH)-1:0]  sp
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = sp_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SW-1:0]    sp_r;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  assign full    = (sp_r == SW'(DEPTH));
  assign empty   = (sp_r == '0);
  assign wr_idx  = sp_r[AW-1:0];
  assign top_idx = wr_idx - AW'(1);
  assign dout    = mem[top_idx];
  assign sp      = sp_r;

  // Storage write; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_idx] <= din;
  end

  // Occupancy counter; push and pop are never asserted together by the owner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 sp_r <= '0;
    else if (push && !full)     sp_r <= sp_r + SW'(1);
    else if (pop && !empty)     sp_r <= sp_r - SW'(1);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with call/return stack and vectored interrupts.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned      PC_W       = PC_W_DEF,
  parameter int unsigned      DEPTH      = DEPTH_DEF,
  parameter int unsigned      N_IRQ      = N_IRQ_DEF,
  parameter logic [PC_W-1:0]  VEC_BASE   = PC_W'(VEC_BASE_DEF),
  parameter int unsigned      VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_inc,
  input  logic                        s_rel_pc,
  input  logic [PC_W-1:0]             target,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        reti,
  input  logic [N_IRQ-1:0]            irq,
  input  logic                        mask_we,
  input  logic [N_IRQ-1:0]            mask_din,
  input  logic                        flag_clr,
  output logic [PC_W-1:0]             pc,
  output logic [N_IRQ-1:0]            irq_ack,
  output logic                        in_isr,
  output logic [sp_width(DEPTH)-1:0]  sp,
  output logic                        uflow,
  output logic                        oflow
);

  localparam int unsigned IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic [PC_W-1:0]  pc_inc, seq, nxt, vec, pc_n, stk_din, stk_top;
  logic [N_IRQ-1:0] pending, mask, irq_q, req, irq_rise, ack_n, pend_clr;
  logic [IW-1:0]    irq_idx;
  logic             irq_found;
  logic             stk_push, stk_pop, stk_full, stk_empty;
  logic             in_isr_n, set_u, set_o;
  act_e             act;

  lifo_stack #(
    .WIDTH (PC_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (stk_din),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty),
    .sp    (sp)
  );

  // Sequential / relative / absolute next-PC candidate.
  always_comb begin
    pc_inc = pc + PC_W'(1);
    seq    = pc + (s_rel_pc ? target : PC_W'(1));
    nxt    = s_inc ? seq : target;
  end

  // Rising-edge detect and lowest-index-first priority encoder over enabled pending lines.
  always_comb begin
    irq_rise  = irq & ~irq_q;
    req       = pending & mask;
    irq_found = 1'b0;
    irq_idx   = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      if (req[i] && !irq_found) begin
        irq_found = 1'b1;
        irq_idx   = IW'(i);
      end
    end
    vec = VEC_BASE + PC_W'(irq_idx) * PC_W'(VEC_STRIDE);
  end

  // Select the winning event of the cycle.
  always_comb begin
    act = ACT_NXT;
    if (reti)                                  act = ACT_RETI;
    else if (pop)                              act = ACT_POP;
    else if (push)                             act = ACT_PUSH;
    else if (irq_found && !in_isr && !stk_full) act = ACT_ENTRY;
  end

  // Next-state values for PC, stack, ISR flag, acknowledge and sticky flags.
  always_comb begin
    pc_n     = nxt;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    stk_din  = pc_inc;
    in_isr_n = in_isr;
    ack_n    = '0;
    pend_clr = '0;
    set_u    = 1'b0;
    set_o    = 1'b0;
    case (act)
      ACT_RETI, ACT_POP: begin
        if (act == ACT_RETI) in_isr_n = 1'b0;
        if (stk_empty) begin
          set_u = 1'b1;
          pc_n  = pc_inc;
        end else begin
          stk_pop = 1'b1;
          pc_n    = stk_top;
        end
      end
      ACT_PUSH: begin
        if (stk_full) set_o    = 1'b1;
        else          stk_push = 1'b1;
      end
      ACT_ENTRY: begin
        stk_push = 1'b1;
        stk_din  = nxt;
        pc_n     = vec;
        in_isr_n = 1'b1;
        ack_n    = N_IRQ'(1) << irq_idx;
        pend_clr = N_IRQ'(1) << irq_idx;
      end
      default: ;
    endcase
  end

  // State registers; a fresh edge on a line being acknowledged keeps it pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= '0;
      pending <= '0;
      mask    <= '0;
      irq_q   <= '0;
      in_isr  <= 1'b0;
      irq_ack <= '0;
      uflow   <= 1'b0;
      oflow   <= 1'b0;
    end else begin
      pc      <= pc_n;
      pending <= (pending & ~pend_clr) | irq_rise;
      irq_q   <= irq;
      if (mask_we) mask <= mask_din;
      in_isr  <= in_isr_n;
      irq_ack <= ack_n;
      uflow   <= set_u | (uflow & ~flag_clr);
      oflow   <= set_o | (oflow & ~flag_clr);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_pc_sequencer;

  localparam int unsigned PC_W       = 10;
  localparam int unsigned DEPTH      = 8;
  localparam int unsigned N_IRQ      = 8;
  localparam int unsigned VEC_BASE   = 'h3C0;
  localparam int unsigned VEC_STRIDE = 4;
  localparam int unsigned PCM        = 1 << PC_W;

  logic             clk, reset;
  logic             s_inc, s_rel_pc, push, pop, reti, mask_we, flag_clr;
  logic [PC_W-1:0]  target, pc;
  logic [N_IRQ-1:0] irq, mask_din, irq_ack;
  logic             in_isr, uflow, oflow;
  logic [3:0]       sp;

  pc_sequencer #(
    .PC_W       (PC_W),
    .DEPTH      (DEPTH),
    .N_IRQ      (N_IRQ),
    .VEC_BASE   (10'h3C0),
    .VEC_STRIDE (VEC_STRIDE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .s_inc    (s_inc),
    .s_rel_pc (s_rel_pc),
    .target   (target),
    .push     (push),
    .pop      (pop),
    .reti     (reti),
    .irq      (irq),
    .mask_we  (mask_we),
    .mask_din (mask_din),
    .flag_clr (flag_clr),
    .pc       (pc),
    .irq_ack  (irq_ack),
    .in_isr   (in_isr),
    .sp       (sp),
    .uflow    (uflow),
    .oflow    (oflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int unsigned  m_pc;
  int unsigned  m_stk[$];
  logic [7:0]   m_pend, m_mask, m_irq_q, m_ack;
  bit           m_isr, m_uf, m_of;

  task automatic model_reset();
    m_pc = 0;
    m_stk.delete();
    m_pend = '0; m_mask = '0; m_irq_q = '0; m_ack = '0;
    m_isr = 0; m_uf = 0; m_of = 0;
  endtask

  // One clock of the sequencer, described as the prioritised list of events.
  task automatic model_step();
    int unsigned nx, npc, idx;
    logic [7:0]  nack, rise;
    bit          su, so, found;
    nx    = s_inc ? ((m_pc + (s_rel_pc ? 32'(target) : 32'd1)) % PCM) : 32'(target);
    rise  = irq & ~m_irq_q;
    nack  = '0;
    su    = 0;
    so    = 0;
    npc   = nx;
    found = 0;
    idx   = 0;
    for (int unsigned i = 0; i < N_IRQ; i++)
      if (!found && m_pend[i] && m_mask[i]) begin
        found = 1;
        idx   = i;
      end
    if (reti || pop) begin
      if (m_stk.size() == 0) begin
        su  = 1;
        npc = (m_pc + 1) % PCM;
      end else begin
        npc = m_stk.pop_back();
      end
      if (reti) m_isr = 0;
    end else if (push) begin
      if (m_stk.size() == DEPTH) so = 1;
      else m_stk.push_back((m_pc + 1) % PCM);
    end else if (found && !m_isr && m_stk.size() < DEPTH) begin
      m_stk.push_back(nx);
      npc          = VEC_BASE + idx * VEC_STRIDE;
      m_isr        = 1;
      m_pend[idx]  = 1'b0;
      nack[idx]    = 1'b1;
    end
    m_pend  = m_pend | rise;
    m_irq_q = irq;
    if (mask_we) m_mask = mask_din;
    m_uf  = su | (m_uf & !flag_clr);
    m_of  = so | (m_of & !flag_clr);
    m_pc  = npc;
    m_ack = nack;
  endtask

  task automatic compare_model(input string pfx);
    check({pfx, "_pc"},     32'(pc),      m_pc);
    check({pfx, "_sp"},     32'(sp),      32'(m_stk.size()));
    check({pfx, "_ack"},    32'(irq_ack), 32'(m_ack));
    check({pfx, "_in_isr"}, 32'(in_isr),  32'(m_isr));
    check({pfx, "_uflow"},  32'(uflow),   32'(m_uf));
    check({pfx, "_oflow"},  32'(oflow),   32'(m_of));
  endtask

  task automatic idle_inputs();
    s_inc = 1'b1; s_rel_pc = 1'b0; target = '0;
    push = 1'b0; pop = 1'b0; reti = 1'b0;
    mask_we = 1'b0; mask_din = '0; flag_clr = 1'b0;
  endtask

  // Advance one clock, update the model, compare shortly after the edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_model("cyc");
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    irq = '0;
    model_reset();
    #1;
    compare_model("rst");
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    irq = '0;
    #2;
    do_reset();

    // Sequential count and wrap
    for (int unsigned i = 1; i <= 5; i++) begin
      cycle();
      check("seq_count", 32'(pc), i);
    end
    s_inc = 1'b0; target = 10'h3FF;
    cycle();
    s_inc = 1'b1;
    cycle();
    check("seq_wrap", 32'(pc), 0);

    // Call and return
    s_inc = 1'b0; target = 10'h010;
    cycle();
    push = 1'b1; target = 10'h100;
    cycle();
    check("call_pc", 32'(pc), 'h100);
    check("call_sp", 32'(sp), 1);
    push = 1'b0; pop = 1'b1;
    cycle();
    check("ret_pc", 32'(pc), 'h011);
    check("ret_sp", 32'(sp), 0);
    pop = 1'b0; s_inc = 1'b1;

    // Two simultaneous interrupts, serviced lowest first, no nesting
    mask_we = 1'b1; mask_din = 8'hFF; s_inc = 1'b0; target = 10'h020;
    cycle();
    mask_we = 1'b0; s_inc = 1'b1; irq = 8'h24;
    cycle();
    check("irq_pre_pc", 32'(pc), 'h021);
    cycle();
    check("irq2_pc",  32'(pc), 'h3C8);
    check("irq2_ack", 32'(irq_ack), 'h04);
    check("irq2_isr", 32'(in_isr), 1);
    reti = 1'b1;
    cycle();
    check("reti_pc",  32'(pc), 'h022);
    check("reti_isr", 32'(in_isr), 0);
    reti = 1'b0;
    cycle();
    check("irq5_pc",  32'(pc), 'h3D4);
    check("irq5_ack", 32'(irq_ack), 'h20);
    reti = 1'b1;
    cycle();
    reti = 1'b0; irq = '0;
    cycle();

    // Masked request stays pending until enabled
    mask_we = 1'b1; mask_din = 8'h00;
    cycle();
    mask_we = 1'b0; irq = 8'h01;
    for (int unsigned i = 0; i < 3; i++) cycle();
    check("masked_ack", 32'(irq_ack), 0);
    check("masked_isr", 32'(in_isr), 0);
    mask_we = 1'b1; mask_din = 8'h01;
    cycle();
    mask_we = 1'b0;
    cycle();
    check("unmask_pc",  32'(pc), 'h3C0);
    check("unmask_ack", 32'(irq_ack), 'h01);

    // Reset in the middle of an ISR
    #2;
    do_reset();
    check("isr_rst_isr", 32'(in_isr), 0);

    // Overflow, underflow, set-wins-clear, flag clear
    for (int unsigned i = 0; i < 9; i++) begin
      push = 1'b1;
      cycle();
    end
    push = 1'b0;
    check("ovf_sp",   32'(sp), 8);
    check("ovf_flag", 32'(oflow), 1);
    for (int unsigned i = 0; i < 9; i++) begin
      pop = 1'b1;
      cycle();
    end
    check("unf_sp",    32'(sp), 0);
    check("unf_flag",  32'(uflow), 1);
    check("ovf_held",  32'(oflow), 1);
    flag_clr = 1'b1;
    cycle();
    check("setwins_uflow", 32'(uflow), 1);
    check("clr_oflow",     32'(oflow), 0);
    pop = 1'b0;
    cycle();
    check("clr_uflow", 32'(uflow), 0);
    flag_clr = 1'b0;

    // Randomized traffic
    for (int unsigned n = 0; n < 3000; n++) begin
      int unsigned r;
      if ($urandom_range(0, 699) == 0) begin
        #2;
        do_reset();
      end
      s_inc    = ($urandom_range(0, 3) != 0);
      s_rel_pc = 1'($urandom_range(0, 1));
      target   = 10'($urandom);
      r        = $urandom_range(0, 99);
      push     = (r < 12) || (r >= 26 && r < 29);
      pop      = (r >= 12 && r < 20) || (r >= 26 && r < 29);
      reti     = (r >= 20 && r < 26);
      if ($urandom_range(0, 5) == 0) irq = irq ^ (8'd1 << $urandom_range(0, 7));
      mask_we  = ($urandom_range(0, 19) == 0);
      mask_din = 8'($urandom);
      flag_clr = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
